// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: registers decode results for EX, inserts bubbles on load-use
// hazards and branch flushes, holds on downstream stall, and counts bubbles (saturating).
module id_ex_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm_ext,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [3:0]        id_alu_op,
    input  logic              id_alu_src,
    input  logic              id_reg_dst,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_mem_to_reg,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_uses_rs,
    output logic              ex_uses_rt,
    output logic [3:0]        ex_alu_op,
    output logic              ex_alu_src,
    output logic              ex_reg_dst,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_mem_to_reg,
    output logic              id_stall_req,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm_ext;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
        logic              uses_rs;
        logic              uses_rt;
        logic [3:0]        alu_op;
        logic              alu_src;
        logic              reg_dst;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
    } stage_t;

    stage_t id_p0;
    stage_t ex_p1;
    logic   flush_pend;
    logic   hazard;
    logic   load_bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign id_p0 = {id_valid, id_pc, id_rs_data, id_rt_data, id_imm_ext,
                    id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt, id_alu_op,
                    id_alu_src, id_reg_dst, id_reg_write, id_mem_read,
                    id_mem_write, id_mem_to_reg};

    // $0 is hardwired to zero, so a load targeting it can never feed a stale value
    assign hazard = ex_p1.valid && ex_p1.mem_read && (ex_p1.rt != '0) && id_valid &&
                    ((id_uses_rs && (ex_p1.rt == id_rs)) ||
                     (id_uses_rt && (ex_p1.rt == id_rt)));

    assign id_stall_req = stall | hazard;
    assign load_bubble  = flush | flush_pend | hazard | ~id_valid;

    // ID -> EX stage boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_p1      <= '0;
            flush_pend <= 1'b0;
            bubble_cnt <= '0;
        end else if (stall) begin
            if (flush)
                flush_pend <= 1'b1;
        end else begin
            flush_pend <= 1'b0;
            if (load_bubble) begin
                ex_p1      <= '0;
                bubble_cnt <= sat_inc(bubble_cnt);
            end else begin
                ex_p1 <= id_p0;
            end
        end
    end

    assign ex_valid      = ex_p1.valid;
    assign ex_pc         = ex_p1.pc;
    assign ex_rs_data    = ex_p1.rs_data;
    assign ex_rt_data    = ex_p1.rt_data;
    assign ex_imm_ext    = ex_p1.imm_ext;
    assign ex_rs         = ex_p1.rs;
    assign ex_rt         = ex_p1.rt;
    assign ex_rd         = ex_p1.rd;
    assign ex_uses_rs    = ex_p1.uses_rs;
    assign ex_uses_rt    = ex_p1.uses_rt;
    assign ex_alu_op     = ex_p1.alu_op;
    assign ex_alu_src    = ex_p1.alu_src;
    assign ex_reg_dst    = ex_p1.reg_dst;
    assign ex_reg_write  = ex_p1.reg_write;
    assign ex_mem_read   = ex_p1.mem_read;
    assign ex_mem_write  = ex_p1.mem_write;
    assign ex_mem_to_reg = ex_p1.mem_to_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios plus randomized traffic checked cycle by cycle
// against a transaction-level model of the EX slot, flush memory and bubble count.
module tb_id_ex_reg;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        uses_rs;
        logic        uses_rt;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        reg_dst;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
    } instr_t;

    logic   clk = 1'b0;
    logic   rst, stall, flush;
    instr_t id_in;

    logic              ex_valid;
    logic [31:0]       ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic              ex_uses_rs, ex_uses_rt;
    logic [3:0]        ex_alu_op;
    logic              ex_alu_src, ex_reg_dst, ex_reg_write;
    logic              ex_mem_read, ex_mem_write, ex_mem_to_reg;
    logic              id_stall_req;
    logic [CNT_W-1:0]  bubble_cnt;
    instr_t            ex_obs;

    assign ex_obs = {ex_valid, ex_pc, ex_rs_data, ex_rt_data, ex_imm_ext, ex_rs, ex_rt, ex_rd,
                     ex_uses_rs, ex_uses_rt, ex_alu_op, ex_alu_src, ex_reg_dst, ex_reg_write,
                     ex_mem_read, ex_mem_write, ex_mem_to_reg};

    id_ex_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .id_valid(id_in.valid), .id_pc(id_in.pc), .id_rs_data(id_in.rs_data),
        .id_rt_data(id_in.rt_data), .id_imm_ext(id_in.imm),
        .id_rs(id_in.rs), .id_rt(id_in.rt), .id_rd(id_in.rd),
        .id_uses_rs(id_in.uses_rs), .id_uses_rt(id_in.uses_rt), .id_alu_op(id_in.alu_op),
        .id_alu_src(id_in.alu_src), .id_reg_dst(id_in.reg_dst), .id_reg_write(id_in.reg_write),
        .id_mem_read(id_in.mem_read), .id_mem_write(id_in.mem_write),
        .id_mem_to_reg(id_in.mem_to_reg),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm_ext(ex_imm_ext), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_uses_rs(ex_uses_rs), .ex_uses_rt(ex_uses_rt), .ex_alu_op(ex_alu_op),
        .ex_alu_src(ex_alu_src), .ex_reg_dst(ex_reg_dst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
        .id_stall_req(id_stall_req), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: the instruction sitting in EX, a remembered flush, the bubble tally
    instr_t m_ex;
    bit     m_flush_pend;
    int     m_cnt;

    task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic bit model_hazard();
        if (!(m_ex.valid && m_ex.mem_read && m_ex.rt != 0 && id_in.valid)) return 0;
        return (id_in.uses_rs && m_ex.rt == id_in.rs) || (id_in.uses_rt && m_ex.rt == id_in.rt);
    endfunction

    function automatic instr_t rand_instr();
        instr_t t;
        t.valid      = ($urandom_range(0, 3) != 0);
        t.pc         = $urandom;
        t.rs_data    = $urandom;
        t.rt_data    = $urandom;
        t.imm        = $urandom;
        t.rs         = 5'($urandom_range(0, 3));
        t.rt         = 5'($urandom_range(0, 3));
        t.rd         = 5'($urandom);
        t.uses_rs    = 1'($urandom_range(0, 1));
        t.uses_rt    = 1'($urandom_range(0, 1));
        t.alu_op     = 4'($urandom);
        t.alu_src    = 1'($urandom_range(0, 1));
        t.reg_dst    = 1'($urandom_range(0, 1));
        t.reg_write  = 1'($urandom_range(0, 1));
        t.mem_read   = ($urandom_range(0, 2) != 0);
        t.mem_write  = 1'($urandom_range(0, 1));
        t.mem_to_reg = 1'($urandom_range(0, 1));
        return t;
    endfunction

    // One clock: check the stall request, advance the model, check the registered outputs
    task automatic step();
        bit hz;
        #1;
        hz = model_hazard();
        check_eq("stall_req", id_stall_req, stall | hz);
        @(posedge clk);
        if (rst) begin
            m_ex = '0; m_flush_pend = 0; m_cnt = 0;
        end else if (stall) begin
            if (flush) m_flush_pend = 1;
        end else begin
            if (flush || m_flush_pend || hz || !id_in.valid) begin
                m_ex  = '0;
                m_cnt = (m_cnt == CNT_MAX) ? CNT_MAX : m_cnt + 1;
            end else begin
                m_ex = id_in;
            end
            m_flush_pend = 0;
        end
        #1;
        check_eq("ex_fields", ex_obs, m_ex);
        check_eq("bubble_cnt", bubble_cnt, m_cnt);
    endtask

    instr_t a, b, c;

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        id_in = rand_instr();
        m_ex = '0; m_flush_pend = 0; m_cnt = 0;
        @(posedge clk);
        #1;

        // Reset with random ID contents and both stall values
        for (int i = 0; i < 2; i++) begin
            stall = 1'(i);
            id_in = rand_instr();
            #1 check_eq("rst_stall_req", id_stall_req, stall);
            step();
            check_eq("rst_ex_zero", ex_obs, 0);
            check_eq("rst_cnt_zero", bubble_cnt, 0);
        end
        rst = 1'b0; stall = 1'b0;

        // Pass-through with a sign-extended negative immediate
        a = rand_instr();
        a.valid = 1; a.imm = 32'hFFFF8000; a.alu_op = 4'h2; a.mem_read = 0;
        id_in = a;
        step();
        check_eq("pass_imm", ex_imm_ext, 32'hFFFF8000);
        check_eq("pass_valid", ex_valid, 1);
        check_eq("pass_alu_op", ex_alu_op, 4'h2);
        check_eq("pass_cnt", bubble_cnt, 0);

        // Load-use: lw writes $5, following add reads $5
        a = rand_instr(); a.valid = 1; a.mem_read = 1; a.rt = 5'd5;
        b = rand_instr(); b.valid = 1; b.mem_read = 0; b.uses_rs = 1; b.rs = 5'd5;
        b.uses_rt = 0;
        id_in = a;
        step();
        id_in = b;
        #1 check_eq("lu_stall_req", id_stall_req, 1);
        step();
        check_eq("lu_bubble_valid", ex_valid, 0);
        check_eq("lu_cnt", bubble_cnt, 1);
        #1 check_eq("lu_release", id_stall_req, 0);
        step();
        check_eq("lu_add_loaded", ex_pc, b.pc);
        check_eq("lu_add_valid", ex_valid, 1);

        // Flush arriving while stalled is remembered until the stall lifts
        a = rand_instr(); a.valid = 1; a.mem_read = 0;
        id_in = a;
        step();
        stall = 1; flush = 1;
        for (int i = 0; i < 3; i++) begin
            id_in = rand_instr();
            step();
            check_eq("fs_hold_pc", ex_pc, a.pc);
            check_eq("fs_hold_valid", ex_valid, 1);
        end
        stall = 0; flush = 0;
        b = rand_instr(); b.valid = 1;
        id_in = b;
        step();
        check_eq("fs_bubble", ex_valid, 0);
        check_eq("fs_cnt", bubble_cnt, 2);
        step();
        check_eq("fs_next_instr", ex_obs, b);

        // No false hazards: load into $0, and matching rt that is not read
        a = rand_instr(); a.valid = 1; a.mem_read = 1; a.rt = 5'd0;
        id_in = a;
        step();
        b = rand_instr(); b.valid = 1; b.uses_rs = 1; b.rs = 0; b.uses_rt = 1; b.rt = 0;
        id_in = b;
        #1 check_eq("nf_rt_zero", id_stall_req, 0);
        c = rand_instr(); c.valid = 1; c.mem_read = 1; c.rt = 5'd7;
        id_in = c;
        step();
        b = rand_instr(); b.valid = 1; b.uses_rt = 0; b.rt = 5'd7; b.uses_rs = 0; b.rs = 5'd3;
        id_in = b;
        #1 check_eq("nf_unused_rt", id_stall_req, 0);
        step();

        // Counter saturation
        rst = 1;
        step();
        rst = 0; flush = 1;
        for (int i = 0; i < 20; i++) begin
            id_in = rand_instr();
            step();
        end
        check_eq("sat_cnt", bubble_cnt, CNT_MAX);
        flush = 0;

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 5) == 0);
            id_in = rand_instr();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
